// File: rtl/blink_rate_select_if.sv
// Button/rate bundle between the pushbutton source and blink_rate_select.
// The slave side is the rate selector; the master side drives btn and observes the rate outputs.
interface blink_rate_select_if #(
   parameter int WIDTH     = 26,
   parameter int NUM_RATES = 4
);
   localparam int IDX_W = (NUM_RATES > 1) ? $clog2(NUM_RATES) : 1;

   logic             btn;
   logic [WIDTH-1:0] threshold;
   logic [IDX_W-1:0] rate_idx;
   logic             press_pulse;

   modport master (output btn, input threshold, input rate_idx, input press_pulse);
   modport slave  (input btn, output threshold, output rate_idx, output press_pulse);
endinterface

// File: rtl/blink_rate_select.sv
// Debounced pushbutton rate selector: each clean press steps rate_idx and reloads threshold = CLOCK_FREQ >> rate_idx.
// Optional macro BLINK_RATE_LONG_PRESS_EN: holding the button 32 debounce periods resets the rate to index 0.
module blink_rate_select #(
   parameter int WIDTH       = 26,
   parameter int CLOCK_FREQ  = 50_000_000,
   parameter int DEBOUNCE_MS = 20,
   parameter int NUM_RATES   = 4
) (
   input logic                clk,
   input logic                rst,
   blink_rate_select_if.slave bus
);
   localparam int IDX_W     = (NUM_RATES > 1) ? $clog2(NUM_RATES) : 1;
   localparam int DB_RAW    = (CLOCK_FREQ / 1000) * DEBOUNCE_MS;
   localparam int DB_CYCLES = (DB_RAW < 1) ? 1 : DB_RAW;
   localparam int CNT_W     = ($clog2(DB_CYCLES) < 1) ? 1 : $clog2(DB_CYCLES);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_RATES - 1);
   localparam logic [WIDTH-1:0] FREQ     = WIDTH'(CLOCK_FREQ);

   localparam logic [1:0] S_IDLE         = 2'd0;
   localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
   localparam logic [1:0] S_HELD         = 2'd2;
   localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

   logic             r_sync1;
   logic             r_sync2;
   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [IDX_W-1:0] r_idx;
   logic [WIDTH-1:0] r_thr;
   logic             r_pulse;

   logic             w_btn_s;
   logic [1:0]       w_state_nx;
   logic [CNT_W-1:0] w_cnt_nx;
   logic             w_accept;
   logic             w_long;
   logic [IDX_W-1:0] w_next_idx;

   assign w_btn_s    = r_sync2;
   assign w_next_idx = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= bus.btn;
         r_sync2 <= r_sync1;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_accept   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_btn_s) begin
               w_state_nx = S_PRESS_WAIT;
               w_cnt_nx   = '0;
            end
         end
         S_PRESS_WAIT: begin
            if (!w_btn_s) begin
               w_state_nx = S_IDLE;
               w_cnt_nx   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nx = S_HELD;
               w_cnt_nx   = '0;
               w_accept   = 1'b1;
            end else begin
               w_cnt_nx = r_cnt + CNT_W'(1);
            end
         end
         S_HELD: begin
            if (!w_btn_s) begin
               w_state_nx = S_RELEASE_WAIT;
               w_cnt_nx   = '0;
            end
         end
         S_RELEASE_WAIT: begin
            // A high sample here is release bounce: return to HELD without a new press.
            if (w_btn_s) begin
               w_state_nx = S_HELD;
               w_cnt_nx   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nx = S_IDLE;
               w_cnt_nx   = '0;
            end else begin
               w_cnt_nx = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
      end
   end

`ifdef BLINK_RATE_LONG_PRESS_EN
   localparam int HOLD_CYCLES = 32 * DB_CYCLES;
   localparam int HOLD_W      = $clog2(HOLD_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   logic [HOLD_W-1:0] r_hold_cnt;
   logic              r_fired;

   assign w_long = (r_state == S_HELD) && w_btn_s && !r_fired && (r_hold_cnt == HOLD_LAST);

   // r_fired survives release bounce so one physical press can trigger the long-press reset only once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hold_cnt <= '0;
         r_fired    <= 1'b0;
      end else begin
         if (r_state != S_HELD)
            r_hold_cnt <= '0;
         else if (w_btn_s && !r_fired)
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
         if (w_long)
            r_fired <= 1'b1;
         else if (r_state == S_IDLE)
            r_fired <= 1'b0;
      end
   end
`else
   assign w_long = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx   <= '0;
         r_thr   <= FREQ;
         r_pulse <= 1'b0;
      end else begin
         r_pulse <= w_accept | w_long;
         if (w_accept) begin
            r_idx <= w_next_idx;
            r_thr <= FREQ >> w_next_idx;
         end else if (w_long) begin
            r_idx <= '0;
            r_thr <= FREQ;
         end
      end
   end

   assign bus.threshold   = r_thr;
   assign bus.rate_idx    = r_idx;
   assign bus.press_pulse = r_pulse;
endmodule

// File: tb/tb_blink_rate_select.sv
// Randomized and directed bench for blink_rate_select against a run-length model of the debounce rules.
// Honours BLINK_RATE_LONG_PRESS_EN the same way as the design.
module tb_blink_rate_select;
   localparam int WIDTH = 10;
   localparam int FREQ  = 1000;
   localparam int NR    = 4;
   localparam int DB    = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   blink_rate_select_if #(.WIDTH(WIDTH), .NUM_RATES(NR)) bus ();

   blink_rate_select #(
      .WIDTH(WIDTH), .CLOCK_FREQ(FREQ), .DEBOUNCE_MS(4), .NUM_RATES(NR)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int n_pulse  = 0;

   bit m_b1, m_b2, m_armed, m_pulse;
   int m_hi, m_lo, m_idx;
`ifdef BLINK_RATE_LONG_PRESS_EN
   int m_held;
   bit m_fired;
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int exp_thr(input int idx);
      return FREQ / (2 ** idx);
   endfunction

   task automatic model_reset();
      m_b1 = 0; m_b2 = 0; m_armed = 1; m_pulse = 0;
      m_hi = 0; m_lo = 0; m_idx = 0;
`ifdef BLINK_RATE_LONG_PRESS_EN
      m_held = 0; m_fired = 0;
`endif
   endtask

   // Press accepted after DB+1 consecutive high synchronized samples while armed;
   // re-armed after DB+1 consecutive low samples.
   task automatic step(input bit b);
      bit s;
      @(negedge clk);
      bus.btn = b;
      @(posedge clk);
      s = m_b2; m_b2 = m_b1; m_b1 = b;
      m_pulse = 0;
      if (s) begin
         m_hi++; m_lo = 0;
         if (m_armed && m_hi == DB + 1) begin
            m_idx = (m_idx + 1) % NR;
            m_armed = 0;
            m_pulse = 1;
`ifdef BLINK_RATE_LONG_PRESS_EN
            m_held = 0;
`endif
         end
`ifdef BLINK_RATE_LONG_PRESS_EN
         else if (!m_armed) begin
            if (m_hi == 1) m_held = 0;
            else m_held++;
            if (m_held == 32 * DB && !m_fired) begin
               m_fired = 1; m_idx = 0; m_pulse = 1;
            end
         end
`endif
      end else begin
         m_lo++; m_hi = 0;
         if (!m_armed && m_lo == DB + 1) begin
            m_armed = 1;
`ifdef BLINK_RATE_LONG_PRESS_EN
            m_fired = 0;
`endif
         end
      end
      #1;
      if (bus.press_pulse === 1'b1) n_pulse++;
      check("press_pulse", bus.press_pulse, m_pulse);
      check("rate_idx", bus.rate_idx, m_idx);
      check("threshold", bus.threshold, exp_thr(m_idx));
   endtask

   task automatic press(input int hold, input int rel);
      repeat (hold) step(1'b1);
      repeat (rel) step(1'b0);
   endtask

   task automatic do_reset();
      // Called at posedge+1; the pulse ends before the next negedge so no edge goes unmodelled.
      #2 rst = 1'b1;
      #1;
      check("rst_idx", bus.rate_idx, 0);
      check("rst_thr", bus.threshold, FREQ);
      check("rst_pulse", bus.press_pulse, 0);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      int p0;
      logic [31:0] thr_seq [4];
      thr_seq[0] = 500; thr_seq[1] = 250; thr_seq[2] = 125; thr_seq[3] = 1000;

      rst = 1'b1;
      bus.btn = 1'b0;
      #12;
      check("init_idx", bus.rate_idx, 0);
      check("init_thr", bus.threshold, FREQ);
      check("init_pulse", bus.press_pulse, 0);
      #4 rst = 1'b0;
      model_reset();

      repeat (20) step(1'b0);
      check("idle_pulses", n_pulse, 0);

      press(20, 10);
      check("first_press_pulses", n_pulse, 1);
      check("first_press_thr", bus.threshold, 500);

      do_reset();
      for (int i = 0; i < 4; i++) begin
         press(12, 10);
         check("seq_thr", bus.threshold, thr_seq[i]);
      end
      check("seq_wrap_idx", bus.rate_idx, 0);

      p0 = n_pulse;
      step(1); step(1); step(0); step(0); step(1); step(1); step(1);
      repeat (10) step(0);
      check("bounce_pulses", n_pulse - p0, 0);
      check("bounce_idx", bus.rate_idx, 0);

      p0 = n_pulse;
      repeat (10) step(1);
      step(0); step(0); step(1); step(1);
      repeat (10) step(0);
      check("release_bounce_pulses", n_pulse - p0, 1);

      press(10, 10);
      check("pre_reset_idx", bus.rate_idx, 2);
      repeat (5) step(1);
      do_reset();
      p0 = n_pulse;
      repeat (10) step(1);
      repeat (10) step(0);
      check("post_reset_pulses", n_pulse - p0, 1);
      check("post_reset_idx", bus.rate_idx, 1);

      press(10, 10);
      p0 = n_pulse;
      repeat (200) step(1);
      repeat (10) step(0);
`ifdef BLINK_RATE_LONG_PRESS_EN
      check("long_pulses", n_pulse - p0, 2);
      check("long_idx", bus.rate_idx, 0);
`else
      check("long_pulses", n_pulse - p0, 1);
      check("long_idx", bus.rate_idx, 3);
`endif

      for (int seg = 0; seg < 250; seg++) begin
         bit lvl;
         int len;
         lvl = 1'($urandom_range(0, 1));
         len = ($urandom_range(0, 19) == 0) ? int'($urandom_range(130, 160)) : int'($urandom_range(1, 10));
         repeat (len) step(lvl);
         if ($urandom_range(0, 99) == 0) do_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
